// File: rtl/lcd_pkg.sv
// lcd_pkg: shared keypad/LCD definitions (key-to-ASCII table, scanner FSM states, LCD character-write constants)
package lcd_pkg;
  typedef enum logic [1:0] {IDLE, CONFIRM, PRESENT, RELEASE} kp_state_e;
  // Indexed by {row, col}: r0 "123A", r1 "456B", r2 "789C", r3 "*0#D"
  localparam logic [7:0] key_lut [16] = '{
    8'h31, 8'h32, 8'h33, 8'h41,
    8'h34, 8'h35, 8'h36, 8'h42,
    8'h37, 8'h38, 8'h39, 8'h43,
    8'h2A, 8'h30, 8'h23, 8'h44
  };
  localparam logic lcd_rs_cmd = 1'b0;
  localparam logic lcd_rs_data = 1'b1;
  localparam logic [7:0] lcd_cmd_clear = 8'h01;
  localparam logic [7:0] lcd_cmd_home = 8'h02;
  localparam logic [7:0] lcd_cmd_entry_inc = 8'h06;
  localparam logic [7:0] lcd_cmd_display_on = 8'h0C;
  localparam logic [7:0] lcd_cmd_function_8b2l = 8'h38;
  function automatic logic [7:0] key_to_ascii(input logic [3:0] idx);
    return key_lut[idx];
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: key handshake bundle; master = scanner (drives key_ascii/key_valid/key_down), slave = LCD-side consumer (drives key_ready)
interface keypad_scanner_if;
  logic [7:0] key_ascii;
  logic key_valid;
  logic key_ready;
  logic key_down;
  modport master (output key_ascii, key_valid, key_down, input key_ready);
  modport slave (input key_ascii, key_valid, key_down, output key_ready);
endinterface

// File: rtl/keypad_row_sync.sv
// keypad_row_sync: 4-bit two-flop synchroniser; clk, rst (async active-low, resets to 4'hF), d async rows in, q synchronised rows out
module keypad_row_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] meta_q, sync_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  assign q = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low key matrix, debounces, and offers each accepted key once on a valid/ready handshake
// Ports: clk; rst (async active-low); row_in[3:0] async active-low rows; col_out[3:0] one-cold column drive;
//        kp (keypad_scanner_if.master): key_ascii, key_valid, key_ready (in), key_down.
// Macro KEYPAD_REPEAT_EN: a key held through RELEASE is re-presented every REPEAT_SCANS matching scans.
module keypad_scanner
  import lcd_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 250
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       row_in,
  output logic [3:0]       col_out,
  keypad_scanner_if.master kp
);
  localparam int div_w = $clog2(SCAN_DIV);
  localparam logic [div_w-1:0] div_last = div_w'(SCAN_DIV - 1);
  localparam logic [3:0] db_n = 4'(DEBOUNCE_SCANS);
  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_cfg_err
    $error("keypad_scanner: parameter out of range");
  end
  logic [3:0] row_s, low;
  logic [div_w-1:0] div_q, div_d;
  logic [1:0] col_q, col_d, hits_q, hits_d, row_enc;
  logic [3:0] idx_q, idx_d, cand_q, cand_d, cnt_q, cnt_d;
  logic [2:0] n_low, hit_sum;
  logic sample, scan_done, res_none, res_single, match, accept;
  kp_state_e state_q, state_d;
  logic [7:0] ascii_q, ascii_d;
  logic valid_q, valid_d, down_q, down_d;
`ifdef KEYPAD_REPEAT_EN
  localparam int rpt_w = $clog2(REPEAT_SCANS + 1);
  logic [rpt_w-1:0] rpt_q, rpt_d;
`endif
  keypad_row_sync u_sync (.clk(clk), .rst(rst), .d(row_in), .q(row_s));
  assign low = ~row_s;
  assign n_low = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
  assign row_enc = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
  assign sample = div_q == div_last;
  assign scan_done = sample && col_q == 2'd3;
  // hits_q saturates at 2: anything beyond one low row over the whole scan is MULTI
  assign hit_sum = {1'b0, hits_q} + n_low;
  always_comb begin
    div_d = sample ? '0 : div_q + div_w'(1);
    col_d = sample ? col_q + 2'd1 : col_q;
    hits_d = !sample ? hits_q : scan_done ? 2'd0 : hit_sum > 3'd1 ? 2'd2 : hit_sum[1:0];
    idx_d = sample && n_low == 3'd1 ? {row_enc, col_q} : idx_q;
    res_none = hit_sum == 3'd0;
    res_single = hit_sum == 3'd1;
  end
  assign match = res_single && idx_d == cand_q;
  // With DEBOUNCE_SCANS=1 the first SINGLE scan in IDLE is already enough
  assign accept = scan_done && res_single &&
                  (state_q == IDLE ? db_n == 4'd1 :
                   state_q == CONFIRM && idx_d == cand_q && cnt_q + 4'd1 == db_n);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cand_d = cand_q;
    ascii_d = ascii_q;
    valid_d = valid_q;
    down_d = down_q;
`ifdef KEYPAD_REPEAT_EN
    rpt_d = rpt_q;
`endif
    case (state_q)
      IDLE: if (scan_done && res_single) begin
        cand_d = idx_d;
        cnt_d = 4'd1;
        state_d = CONFIRM;
      end
      CONFIRM: if (scan_done) begin
        cnt_d = match ? cnt_q + 4'd1 : 4'd0;
        state_d = match ? CONFIRM : IDLE;
      end
      // Scan results are ignored here: a release before the handshake never withdraws the key
      PRESENT: if (valid_q && kp.key_ready) begin
        valid_d = 1'b0;
        cnt_d = 4'd0;
        state_d = RELEASE;
`ifdef KEYPAD_REPEAT_EN
        rpt_d = '0;
`endif
      end
      RELEASE: if (scan_done) begin
        cnt_d = res_none ? cnt_q + 4'd1 : 4'd0;
        if (res_none && cnt_q + 4'd1 == db_n) begin
          cnt_d = 4'd0;
          down_d = 1'b0;
          state_d = IDLE;
        end
`ifdef KEYPAD_REPEAT_EN
        rpt_d = match ? rpt_q + rpt_w'(1) : '0;
        if (match && rpt_q + rpt_w'(1) == rpt_w'(REPEAT_SCANS)) begin
          rpt_d = '0;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      ascii_d = key_to_ascii(idx_d);
      cand_d = idx_d;
      valid_d = 1'b1;
      down_d = 1'b1;
      cnt_d = 4'd0;
      state_d = PRESENT;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      div_q <= '0;
      col_q <= 2'd0;
      hits_q <= 2'd0;
      idx_q <= 4'd0;
      cand_q <= 4'd0;
      cnt_q <= 4'd0;
      state_q <= IDLE;
      ascii_q <= 8'h00;
      valid_q <= 1'b0;
      down_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q <= '0;
`endif
    end else begin
      div_q <= div_d;
      col_q <= col_d;
      hits_q <= hits_d;
      idx_q <= idx_d;
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      ascii_q <= ascii_d;
      valid_q <= valid_d;
      down_q <= down_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q <= rpt_d;
`endif
    end
  assign col_out = ~(4'b0001 << col_q);
  assign kp.key_ascii = ascii_q;
  assign kp.key_valid = valid_q;
  assign kp.key_down = down_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized scan-level stimulus against a key-event reference model with a transfer scoreboard
module tb_keypad_scanner;
  localparam int sd = 4, db = 2, rs = 3, scan_cyc = 4 * sd;
  typedef struct {
    logic [7:0] ascii;
    int scan;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] row_in, col_out, col_exp;
  logic [15:0] pressed = '0;
  exp_t sb[$];
  string keys = "123A456B789C*0#D";
  int checks = 0, passes = 0, cyc = 0, scan_no = 0;
  int mode = 0, run = 0, run_key = 0, pend_key = 0, rel = 0, rpt = 0;
  bit down = 1'b0;
  keypad_scanner_if kif ();
  keypad_scanner #(.SCAN_DIV(sd), .DEBOUNCE_SCANS(db), .REPEAT_SCANS(rs)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out), .kp(kif)
  );
  always #5 clk = ~clk;
  // Physical matrix: a pressed key pulls its row low while its column is driven low
  always_comb for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask
  always @(negedge clk) if (rst) begin
    if (cyc < 4 * scan_cyc && cyc % sd == 0) begin
      col_exp = 4'b1111 ^ (4'b0001 << (cyc / sd % 4));
      chk("col_out_step", col_out, col_exp);
    end
    if (kif.key_valid && kif.key_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL xfer_spurious: got key 0x%h, expected no transfer (cycle %0d)", kif.key_ascii, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("xfer_key", kif.key_ascii, e.ascii);
        chk("xfer_scan", cyc / scan_cyc, e.scan);
        chk("xfer_phase", cyc % scan_cyc, 0);
      end
    end
  end
  // One full scan with a fixed set of pressed keys and a fixed key_ready level
  task automatic do_scan(input logic [15:0] pat, input bit rdy);
    int n, k;
    exp_t e;
    pressed = pat;
    kif.key_ready = rdy;
    if (mode == 1 && rdy) begin
      e.ascii = keys[pend_key];
      e.scan = scan_no;
      sb.push_back(e);
      mode = 2;
      rel = 0;
      rpt = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("key_valid", kif.key_valid, int'(mode == 1));
    chk("key_down", kif.key_down, int'(down));
    if (mode == 1) chk("key_ascii_hold", kif.key_ascii, keys[pend_key]);
    repeat (scan_cyc - 2) @(posedge clk);
    #1;
    n = $countones(pat);
    k = 0;
    for (int i = 15; i >= 0; i--) if (pat[i]) k = i;
    if (mode == 0) begin
      if (n == 1 && (run == 0 || k == run_key)) begin
        run_key = k;
        run++;
      end else run = 0;
      if (run >= db) begin
        mode = 1;
        pend_key = run_key;
        down = 1'b1;
        run = 0;
      end
    end else if (mode == 2) begin
      if (n == 0) begin
        rpt = 0;
        rel++;
        if (rel == db) begin
          mode = 0;
          down = 1'b0;
          rel = 0;
        end
      end else begin
        rel = 0;
`ifdef KEYPAD_REPEAT_EN
        if (n == 1 && k == pend_key) begin
          rpt++;
          if (rpt == rs) begin
            rpt = 0;
            mode = 1;
          end
        end else rpt = 0;
`else
        rpt = 0;
`endif
      end
    end
    scan_no++;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    pressed = '0;
    kif.key_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_col_out", col_out, 4'b1110);
    chk("rst_key_valid", kif.key_valid, 0);
    chk("rst_key_ascii", kif.key_ascii, 0);
    chk("rst_key_down", kif.key_down, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    mode = 0;
    run = 0;
    rel = 0;
    rpt = 0;
    down = 1'b0;
    scan_no = 0;
    sb.delete();
  endtask
  task automatic random_scans(input int n);
    logic [15:0] pat;
    int left, kind;
    left = 0;
    pat = '0;
    for (int i = 0; i < n; i++) begin
      if (left == 0) begin
        kind = $urandom_range(0, 9);
        pat = kind < 3 ? 16'h0 : kind < 9 ? 16'h1 << $urandom_range(0, 15) :
              (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        left = $urandom_range(1, 6);
      end
      do_scan(pat, $urandom_range(0, 3) != 0);
      left--;
    end
  endtask
  initial begin
    kif.key_ready = 1'b0;
    do_reset();
    repeat (2) do_scan(16'h0, 1'b1);
    repeat (3) do_scan(16'h1 << 6, 1'b1);
    repeat (3) do_scan(16'h0, 1'b1);
    repeat (8) do_scan(16'h1 << 14, 1'b0);
    repeat (2) do_scan(16'h1 << 14, 1'b1);
    repeat (3) do_scan(16'h0, 1'b1);
    do_scan(16'h1, 1'b1);
    repeat (2) do_scan(16'h0, 1'b1);
    repeat (3) begin
      do_scan(16'h1, 1'b1);
      do_scan(16'h2, 1'b1);
    end
    repeat (2) do_scan(16'h0, 1'b1);
    repeat (3) do_scan(16'h0081, 1'b1);
    repeat (4) do_scan(16'h1, 1'b1);
    repeat (3) do_scan(16'h0, 1'b1);
    repeat (12) do_scan(16'h1 << 15, 1'b1);
    repeat (3) do_scan(16'h0, 1'b1);
    random_scans(250);
    repeat (3) do_scan(16'h1 << 3, 1'b0);
    chk("sb_empty_before_reset", sb.size(), 0);
    do_reset();
    random_scans(120);
    repeat (4) do_scan(16'h0, 1'b1);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
